pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS datapath. It drives the PC enable, the IF/ID register's write-enable and flush, and the ID/EX bubble insert. It arbitrates four sources: branch/jump redirect from EX, load-use hazards, the multi-cycle MULT/DIV unit (HI/LO) and instruction-memory not-ready. It also contains the MDU busy sequencer and a stall performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/mdu_sequencer.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: MDU sequencer states,
// the hardwired-zero register index and the NOP word used by the flush paths.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/mdu_sequencer.sv
// Tracks a multi-cycle MULT/DIV from issue to the HI/LO write: IDLE -> BUSY for
// MDU_CYCLES-1 cycles -> DONE for one cycle (mdu_done pulse) -> IDLE.
module mdu_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MDU_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       issue,
   output mdu_state_e mdu_state,
   output logic       mdu_done
);

   // Counter only ever holds MDU_CYCLES-2 down to 0.
   localparam int unsigned CW = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES - 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_CYCLES - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdu_state <= MDU_IDLE;
         cnt       <= '0;
         mdu_done  <= 1'b0;
      end else begin
         mdu_done <= 1'b0;
         unique case (mdu_state)
            MDU_IDLE: begin
               if (issue) begin
                  mdu_state <= MDU_BUSY;
                  cnt       <= CNT_LOAD;
               end
            end
            MDU_BUSY: begin
               if (cnt == '0) begin
                  mdu_state <= MDU_DONE;
                  mdu_done  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            MDU_DONE: mdu_state <= MDU_IDLE;
            default:  mdu_state <= MDU_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: arbitrates redirect, load-use, HI/LO busy and
// imem-not-ready into PC / IF/ID / ID/EX controls, and counts stalled cycles.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MDU_CYCLES  = 32,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   imem_valid,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_uses_rt,
   input  logic                   id_is_mdu,
   input  logic                   id_reads_hilo,
   input  logic                   ex_mem_read,
   input  logic [4:0]             ex_rt,
   input  logic                   ex_redirect,
   output logic                   pc_en,
   output logic                   ifid_en,
   output logic                   ifid_flush,
   output logic                   idex_bubble,
   output logic                   mdu_done,
   output logic [1:0]             mdu_state,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic       lu;
   logic       hl;
   logic       id_stall;
   logic       issue;
   mdu_state_e seq_state;

   assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign hl       = (id_reads_hilo || id_is_mdu) && (seq_state != MDU_IDLE);
   assign id_stall = lu || hl;
   assign issue    = id_is_mdu && !id_stall && !ex_redirect;

   mdu_sequencer #(
      .MDU_CYCLES (MDU_CYCLES)
   ) u_mdu_sequencer (
      .clk       (clk),
      .rst_n     (reset),
      .issue     (issue),
      .mdu_state (seq_state),
      .mdu_done  (mdu_done)
   );

   assign mdu_state = seq_state;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (ex_redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (id_stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end else if (!imem_valid) begin
         // ID instruction moves on; a NOP takes its place.
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (!pc_en && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned MDU_CYCLES  = 4;
   localparam int unsigned STALL_CNT_W = 4;

   logic       clk;
   logic       reset;
   logic       imem_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       id_is_mdu;
   logic       id_reads_hilo;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       ex_redirect;
   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       mdu_done;
   logic [1:0] mdu_state;
   logic [3:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   // Model: m_left = cycles of HI/LO occupancy still ahead (0 = idle, 1 = done cycle).
   int m_left = 0;
   int m_cnt  = 0;
   int n_left = 0;
   int n_cnt  = 0;
   logic [10:0] exp_vec;
   logic [10:0] act_vec;

   assign act_vec = {pc_en, ifid_en, ifid_flush, idex_bubble, mdu_done, mdu_state, stall_cnt};

   pipe_hazard_ctrl #(
      .MDU_CYCLES  (MDU_CYCLES),
      .STALL_CNT_W (STALL_CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_valid    (imem_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rt    (id_uses_rt),
      .id_is_mdu     (id_is_mdu),
      .id_reads_hilo (id_reads_hilo),
      .ex_mem_read   (ex_mem_read),
      .ex_rt         (ex_rt),
      .ex_redirect   (ex_redirect),
      .pc_en         (pc_en),
      .ifid_en       (ifid_en),
      .ifid_flush    (ifid_flush),
      .idex_bubble   (idex_bubble),
      .mdu_done      (mdu_done),
      .mdu_state     (mdu_state),
      .stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic model_eval;
      logic       lu;
      logic       hl;
      logic [3:0] ctl;
      logic [1:0] st;
      #1;
      if (!reset) begin
         exp_vec = {4'b0011, 1'b0, 2'd0, 4'd0};
         n_left  = 0;
         n_cnt   = 0;
      end else begin
         lu = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
         hl = (id_reads_hilo || id_is_mdu) && (m_left > 0);
         if (ex_redirect)      ctl = 4'b1111;
         else if (lu || hl)    ctl = 4'b0001;
         else if (!imem_valid) ctl = 4'b0110;
         else                  ctl = 4'b1100;
         st = (m_left == 0) ? 2'd0 : (m_left == 1) ? 2'd2 : 2'd1;
         exp_vec = {ctl, (m_left == 1), st, 4'(m_cnt)};
         n_cnt = (!ctl[3] && m_cnt < 15) ? m_cnt + 1 : m_cnt;
         if (m_left > 0)                               n_left = m_left - 1;
         else if (id_is_mdu && !lu && !ex_redirect)    n_left = MDU_CYCLES;
         else                                          n_left = 0;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      m_left = n_left;
      m_cnt  = n_cnt;
   endtask

   task automatic clean_inputs;
      imem_valid    = 1'b1;
      id_rs         = 5'd0;
      id_rt         = 5'd0;
      id_uses_rt    = 1'b0;
      id_is_mdu     = 1'b0;
      id_reads_hilo = 1'b0;
      ex_mem_read   = 1'b0;
      ex_rt         = 5'd0;
      ex_redirect   = 1'b0;
   endtask

   task automatic rand_inputs;
      imem_valid    = ($urandom_range(0, 3) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rt         = 5'($urandom_range(0, 3));
      id_uses_rt    = 1'($urandom_range(0, 1));
      id_is_mdu     = ($urandom_range(0, 3) == 0);
      id_reads_hilo = ($urandom_range(0, 3) == 0);
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_redirect   = ($urandom_range(0, 7) == 0);
   endtask

   task automatic do_reset;
      reset = 1'b0;
      repeat (2) begin
         rand_inputs();
         model_eval();
         tick();
      end
      clean_inputs();
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_vec cycle %0d: got %b want %b", i, act_vec, exp_vec);
         end
         checks++;
         if ({pc_en, ifid_en, ifid_flush, idex_bubble, stall_cnt} !== 8'b0011_0000) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %b want 00110000", i,
                     {pc_en, ifid_en, ifid_flush, idex_bubble, stall_cnt});
         end
         tick();
      end
      clean_inputs();
      reset = 1'b1;
      model_eval();
      checks++;
      if ({pc_en, ifid_en} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release: got %b want 11", {pc_en, ifid_en});
      end
      tick();
   endtask

   task automatic test_load_use;
      do_reset();
      ex_mem_read = 1'b1;
      ex_rt       = 5'd8;
      id_rs       = 5'd8;
      model_eval();
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b0001) begin
         errors++;
         $display("FAIL load_use_stall: got %b want 0001", {pc_en, ifid_en, ifid_flush, idex_bubble});
      end
      tick();
      clean_inputs();
      model_eval();
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble, stall_cnt} !== 8'b1100_0001) begin
         errors++;
         $display("FAIL load_use_release: got %b want 11000001",
                  {pc_en, ifid_en, ifid_flush, idex_bubble, stall_cnt});
      end
      tick();
      ex_mem_read = 1'b1;
      ex_rt       = 5'd0;
      id_rs       = 5'd0;
      model_eval();
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1100) begin
         errors++;
         $display("FAIL load_use_r0: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_bubble});
      end
      tick();
   endtask

   task automatic test_mdu;
      do_reset();
      id_is_mdu = 1'b1;
      model_eval();
      checks++;
      if (act_vec !== exp_vec) begin
         errors++;
         $display("FAIL mdu_issue: got %b want %b", act_vec, exp_vec);
      end
      tick();
      id_is_mdu     = 1'b0;
      id_reads_hilo = 1'b1;
      for (int i = 0; i < 4; i++) begin
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL mdu_busy_vec cycle %0d: got %b want %b", i, act_vec, exp_vec);
         end
         checks++;
         if ({pc_en, mdu_done} !== {1'b0, (i == 3)}) begin
            errors++;
            $display("FAIL mdu_stall cycle %0d: got pc_en=%b mdu_done=%b want 0 %b",
                     i, pc_en, mdu_done, (i == 3));
         end
         tick();
      end
      model_eval();
      checks++;
      if ({pc_en, mdu_state, stall_cnt} !== 7'b1_00_0100) begin
         errors++;
         $display("FAIL mdu_release: got %b want 1000100", {pc_en, mdu_state, stall_cnt});
      end
      tick();
   endtask

   task automatic test_redirect;
      do_reset();
      ex_redirect = 1'b1;
      ex_mem_read = 1'b1;
      ex_rt       = 5'd3;
      id_rs       = 5'd3;
      imem_valid  = 1'b0;
      id_is_mdu   = 1'b1;
      model_eval();
      checks++;
      if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1111) begin
         errors++;
         $display("FAIL redirect_prio: got %b want 1111", {pc_en, ifid_en, ifid_flush, idex_bubble});
      end
      tick();
      clean_inputs();
      model_eval();
      checks++;
      if (mdu_state !== 2'd0) begin
         errors++;
         $display("FAIL redirect_no_issue: got mdu_state=%0d want 0", mdu_state);
      end
      tick();
   endtask

   task automatic test_imem;
      do_reset();
      imem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         model_eval();
         checks++;
         if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b0110) begin
            errors++;
            $display("FAIL imem_wait cycle %0d: got %b want 0110", i,
                     {pc_en, ifid_en, ifid_flush, idex_bubble});
         end
         tick();
      end
      clean_inputs();
      model_eval();
      checks++;
      if (stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL imem_count: got %0d want 2", stall_cnt);
      end
      tick();
   endtask

   task automatic test_saturation;
      do_reset();
      imem_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL sat_vec cycle %0d: got %b want %b", i, act_vec, exp_vec);
         end
         tick();
      end
      model_eval();
      checks++;
      if (stall_cnt !== 4'hF) begin
         errors++;
         $display("FAIL sat_hold: got %h want f", stall_cnt);
      end
      tick();
      clean_inputs();
   endtask

   task automatic test_abort;
      do_reset();
      id_is_mdu = 1'b1;
      model_eval();
      tick();
      clean_inputs();
      model_eval();
      checks++;
      if (mdu_state !== 2'd1) begin
         errors++;
         $display("FAIL abort_busy: got mdu_state=%0d want 1", mdu_state);
      end
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({mdu_state, mdu_done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_immediate: got state=%0d done=%b want 0 0", mdu_state, mdu_done);
      end
      m_left = 0;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) begin
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort_vec cycle %0d: got %b want %b", i, act_vec, exp_vec);
         end
         tick();
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL abort_after cycle %0d: got %b want %b", i, act_vec, exp_vec);
         end
         tick();
      end
   endtask

   task automatic test_random;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL random cycle %0d: got %b want %b", i, act_vec, exp_vec);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b0;
      clean_inputs();
      test_reset();
      test_load_use();
      test_mdu();
      test_redirect();
      test_imem();
      test_saturation();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
